// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB memory responder slice.
// Holds the FSM state encoding, bus width defaults and the read-only status addresses.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 16;

    localparam logic [7:0] APB_STAT_ADDR = 8'h10;
    localparam logic [7:0] APB_CNT_ADDR  = 8'h11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable wait-state down-counter for the APB responder.
// done_next flags the last wait cycle, so the response can be loaded on the following edge.
module apb_wait_ctr (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       clr,
    output logic       done_next
);

    logic [3:0] count_r;

    // Wait-state count: clear on abort, load at setup, decrement per access cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_r <= 4'd0;
        end else if (clr) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end
    end

    assign done_next = (count_r == 4'd1);

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer with a register memory, programmable wait states, two read-only
// status words (error count and completed-transfer count) and PSLVERR generation.
module apb_mem_responder #(
    parameter int                    ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = apb_pkg::APB_DATA_WIDTH,
    parameter int                    DEPTH      = 2 ** ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = apb_pkg::APB_STAT_ADDR,
    parameter logic [ADDR_WIDTH-1:0] CNT_ADDR   = apb_pkg::APB_CNT_ADDR
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            wait_cfg,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    import apb_pkg::*;

    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    apb_state_e            state_r;
    apb_state_e            state_nxt_s;

    logic                  write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] cnt_r;
    logic [DATA_WIDTH-1:0] err_r;

    logic                  pready_r;
    logic                  pslverr_r;
    logic [DATA_WIDTH-1:0] prdata_r;
    logic                  pready_nxt_s;
    logic                  pslverr_nxt_s;
    logic [DATA_WIDTH-1:0] prdata_nxt_s;

    logic                  setup_s;
    logic                  access_s;
    logic                  latch_s;
    logic                  ctr_load_s;
    logic                  ctr_dec_s;
    logic                  ctr_clr_s;
    logic                  ctr_done_next_s;
    logic                  complete_s;
    logic                  commit_wr_s;

    logic                  cur_write_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic                  rsp_err_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;

    assign setup_s  = psel && !penable;
    assign access_s = psel && penable;

    apb_wait_ctr u_wait_ctr (
        .pclk      (pclk),
        .presetn   (presetn),
        .load      (ctr_load_s),
        .load_val  (wait_cfg),
        .dec       (ctr_dec_s),
        .clr       (ctr_clr_s),
        .done_next (ctr_done_next_s)
    );

    // Response decode; a zero-wait transfer loads straight from the setup-phase bus
    always_comb begin
        cur_write_s = write_r;
        cur_addr_s  = addr_r;
        rsp_err_s   = 1'b0;
        rsp_data_s  = '0;
        if (state_r == IDLE) begin
            cur_write_s = pwrite;
            cur_addr_s  = paddr;
        end else begin
            cur_write_s = write_r;
            cur_addr_s  = addr_r;
        end
        if (cur_write_s) begin
            rsp_err_s  = (cur_addr_s == STAT_ADDR) || (cur_addr_s == CNT_ADDR);
            rsp_data_s = '0;
        end else if (cur_addr_s == STAT_ADDR) begin
            rsp_data_s = err_r;
        end else if (cur_addr_s == CNT_ADDR) begin
            rsp_data_s = cnt_r;
        end else begin
            rsp_data_s = mem_r[cur_addr_s];
        end
    end

    // Next-state and next-output logic; pready only drops while waiting
    always_comb begin
        state_nxt_s   = state_r;
        pready_nxt_s  = 1'b1;
        prdata_nxt_s  = '0;
        pslverr_nxt_s = 1'b0;
        latch_s       = 1'b0;
        ctr_load_s    = 1'b0;
        ctr_dec_s     = 1'b0;
        ctr_clr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    latch_s = 1'b1;
                    if (wait_cfg == 4'd0) begin
                        state_nxt_s   = DONE;
                        prdata_nxt_s  = rsp_data_s;
                        pslverr_nxt_s = rsp_err_s;
                    end else begin
                        ctr_load_s   = 1'b1;
                        pready_nxt_s = 1'b0;
                        state_nxt_s  = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!psel) begin
                    ctr_clr_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (penable) begin
                    ctr_dec_s = 1'b1;
                    if (ctr_done_next_s) begin
                        state_nxt_s   = DONE;
                        prdata_nxt_s  = rsp_data_s;
                        pslverr_nxt_s = rsp_err_s;
                    end else begin
                        pready_nxt_s = 1'b0;
                    end
                end else begin
                    pready_nxt_s = 1'b0;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered bus response
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready_r  <= 1'b1;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            pready_r  <= pready_nxt_s;
            prdata_r  <= prdata_nxt_s;
            pslverr_r <= pslverr_nxt_s;
        end
    end

    // Setup-phase capture of the transfer attributes
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (latch_s) begin
            write_r <= pwrite;
            addr_r  <= paddr;
            wdata_r <= pwdata;
        end
    end

    // pslverr_r is still the response being presented during the DONE cycle
    assign complete_s  = (state_r == DONE) && access_s;
    assign commit_wr_s = complete_s && write_r && !pslverr_r;

    // Register memory, cleared by reset and written only on a completed error-free write
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (commit_wr_s) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    // Completed-transfer and error counters
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_r <= '0;
            err_r <= '0;
        end else if (complete_s) begin
            if (pslverr_r) begin
                err_r <= err_r + DATA_ONE;
            end else begin
                cnt_r <= cnt_r + DATA_ONE;
            end
        end
    end

    assign pready  = pready_r;
    assign prdata  = prdata_r;
    assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Randomised self-checking bench for apb_mem_responder against a transfer-level model
// (word array plus completed/error counts updated once per finished transfer).
module tb_apb_mem_responder;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [3:0]  wait_cfg;
    logic        pready;
    logic [15:0] prdata;
    logic        pslverr;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_cnt;
    logic [15:0] ref_err;
    logic [15:0] last_rd;

    apb_mem_responder dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .wait_cfg (wait_cfg),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'h0000;
        end
        ref_cnt = 16'h0000;
        ref_err = 16'h0000;
    endtask

    task automatic go_idle(input int cycles);
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (cycles) begin
            @(negedge pclk);
            check_eq("idle_pready", 32'(pready), 32'd1);
            check_eq("idle_prdata", 32'(prdata), 32'd0);
            check_eq("idle_pslverr", 32'(pslverr), 32'd0);
        end
    endtask

    // Full transfer: setup, access with scrambled bus, wait for pready, compare, update model
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [15:0] d, input logic [3:0] wc);
        logic [15:0] exp_data;
        logic        exp_err;
        int          waits;
        exp_err = wr && (a == 8'h10 || a == 8'h11);
        if (wr)              exp_data = 16'h0000;
        else if (a == 8'h10) exp_data = ref_err;
        else if (a == 8'h11) exp_data = ref_cnt;
        else                 exp_data = ref_mem[a];
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = wc;
        @(posedge pclk); #1;
        penable  = 1'b1;
        pwrite   = 1'($urandom);
        paddr    = 8'($urandom);
        pwdata   = 16'($urandom);
        wait_cfg = 4'($urandom);
        waits = 0;
        @(negedge pclk);
        while (!pready && waits < 20) begin
            waits++;
            @(negedge pclk);
        end
        check_eq("xfer_waits", 32'(waits), 32'(wc));
        check_eq("xfer_prdata", 32'(prdata), 32'(exp_data));
        check_eq("xfer_pslverr", 32'(pslverr), 32'(exp_err));
        last_rd = prdata;
        if (exp_err) begin
            ref_err++;
        end else begin
            ref_cnt++;
            if (wr) ref_mem[a] = d;
        end
    endtask

    // Transfer abandoned after k access cycles (k == wc drops psel in the DONE cycle)
    task automatic xfer_abort(input logic wr, input logic [7:0] a, input logic [15:0] d,
                              input logic [3:0] wc, input int k);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cfg = wc;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (k - 1) begin
            @(posedge pclk); #1;
        end
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check_eq("abort_pready", 32'(pready), 32'd1);
        check_eq("abort_prdata", 32'(prdata), 32'd0);
        check_eq("abort_pslverr", 32'(pslverr), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        int         sel;
        int         kk;
        logic [3:0] rwc;

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 16'h0000; wait_cfg = 4'd0;
        ref_reset();
        #12;
        check_eq("rst_pready", 32'(pready), 32'd1);
        check_eq("rst_prdata", 32'(prdata), 32'd0);
        check_eq("rst_pslverr", 32'(pslverr), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        go_idle(3);

        xfer(1'b0, 8'h05, 16'h0000, 4'd0);
        check_eq("plan_rd05_reset", 32'(last_rd), 32'h0000);
        xfer(1'b1, 8'h05, 16'hBEEF, 4'd0);
        xfer(1'b0, 8'h05, 16'h0000, 4'd0);
        check_eq("plan_rd05_beef", 32'(last_rd), 32'hBEEF);
        xfer(1'b0, 8'h11, 16'h0000, 4'd0);
        check_eq("plan_cnt3", 32'(last_rd), 32'd3);
        xfer(1'b0, 8'h05, 16'h0000, 4'd3);
        check_eq("plan_rd05_wait3", 32'(last_rd), 32'hBEEF);

        xfer(1'b1, 8'h10, 16'h1234, 4'd0);
        xfer(1'b0, 8'h10, 16'h0000, 4'd0);
        check_eq("plan_stat_err1", 32'(last_rd), 32'h0001);
        xfer(1'b0, 8'h11, 16'h0000, 4'd1);
        check_eq("plan_cnt_unchanged", 32'(last_rd), 32'd6);

        xfer_abort(1'b1, 8'h20, 16'hAAAA, 4'd5, 1);
        xfer(1'b0, 8'h20, 16'h0000, 4'd0);
        check_eq("plan_abort_nowrite", 32'(last_rd), 32'h0000);
        xfer(1'b0, 8'h11, 16'h0000, 4'd0);

        // penable without a setup phase must be ignored
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h30; pwdata = 16'h5A5A; wait_cfg = 4'd0;
        repeat (2) begin
            @(negedge pclk);
            check_eq("stray_pready", 32'(pready), 32'd1);
            check_eq("stray_prdata", 32'(prdata), 32'd0);
        end
        go_idle(1);
        xfer(1'b0, 8'h30, 16'h0000, 4'd0);
        xfer(1'b0, 8'h11, 16'h0000, 4'd2);

        for (int it = 0; it < 80; it++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0:       ra = 8'h10;
                1:       ra = 8'h11;
                2:       ra = 8'h05;
                3:       ra = 8'h20;
                default: ra = 8'($urandom_range(0, 7)) + 8'h40;
            endcase
            kk = int'($urandom_range(0, 9));
            if (kk == 0) begin
                rwc = 4'($urandom_range(1, 4));
                xfer_abort(1'($urandom), ra, 16'($urandom), rwc, int'($urandom_range(1, int'(rwc))));
            end else if (kk == 1) begin
                go_idle(1);
            end else begin
                xfer(1'($urandom), ra, 16'($urandom), 4'($urandom_range(0, 4)));
            end
        end
        xfer(1'b0, 8'h11, 16'h0000, 4'd0);
        xfer(1'b0, 8'h10, 16'h0000, 4'd0);

        // Reset asserted while the responder is waiting
        xfer(1'b1, 8'h05, 16'hC0DE, 4'd0);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05; wait_cfg = 4'd6;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check_eq("midrst_pre_pready", 32'(pready), 32'd0);
        #1;
        presetn = 1'b0;
        #1;
        check_eq("midrst_pready", 32'(pready), 32'd1);
        check_eq("midrst_pslverr", 32'(pslverr), 32'd0);
        check_eq("midrst_prdata", 32'(prdata), 32'd0);
        psel = 1'b0; penable = 1'b0;
        ref_reset();
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b0, 8'h11, 16'h0000, 4'd0);
        check_eq("midrst_cnt0", 32'(last_rd), 32'd0);
        xfer(1'b0, 8'h05, 16'h0000, 4'd2);
        check_eq("midrst_mem_clr", 32'(last_rd), 32'h0000);
        go_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
